// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Types and constants shared by the data-memory responder and its RAM.
//   - dmem_state_t : responder FSM state (IDLE waits for a request, BUSY
//                    counts down wait states).
//   - WAIT_W       : width of the wait-state counter.
//   - laneMask     : one-hot byte enable for a byte lane.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dmem_state_t;

    localparam int WAIT_W = 4;

    // Byte lane 0 is bits [7:0] of the word, lane 3 is bits [31:24].
    function automatic logic [3:0] laneMask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram
//   Word-organised data RAM. One asynchronous read port and one
//   synchronous write port with per-byte enables. Contents are not reset.
//
//   Parameters
//     DEPTH_WORDS : number of 32-bit words (power of two)
//     AW          : word index width, derived from DEPTH_WORDS
//   Ports
//     clk    in   clock; writes land on the rising edge
//     byteEn in   4  per-lane write enable (lane 0 = bits [7:0])
//     waddr  in   AW write word index
//     wdata  in   32 write data, lane b taken from wdata[8b+7:8b]
//     raddr  in   AW read word index
//     rdata  out  32 read data, combinational from raddr
module dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    byteEn,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) begin
                mem[waddr][b] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the M stage. Serves one load or store at a
//   time, inserting WAIT wait states and holding the pipeline with stallM
//   until the access completes. Loads return the whole word; byte
//   extraction for lb happens in writeback.
//
//   Parameters
//     DEPTH_WORDS : words of storage (power of two, >= 4)
//     WAIT        : extra cycles per access, 0..15
//   Ports
//     clk        in   clock
//     reset      in   synchronous, active-high
//     memreqM    in   valid load/store in M
//     memwriteM  in   1 = store, 0 = load
//     sbM        in   store-byte (with memwriteM)
//     aluoutM    in   32 byte address (upper bits alias)
//     writedataM in   32 store data (sb uses [7:0])
//     readdataM  out  32 load data in the completion cycle, else 0
//     stallM     out  hold F/D/E/M while the access is in progress
//     errM       out  sticky: a misaligned sw was seen
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic        sbM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        errM
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam bit ZERO_WAIT = (WAIT == 0);
    // Count loaded on acceptance; the access completes when it reaches 0.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT > 0) ? WAIT - 1 : 0);

    dmem_state_t       state;
    logic [WAIT_W-1:0] cnt;

    logic [AW-1:0] wordIdx;
    logic [1:0]    lane;
    logic          aligned;
    logic          complete;
    logic          isStore;
    logic          storeOk;
    logic          misalignedSw;
    logic [3:0]    byteEn;
    logic [31:0]   wrData;
    logic [31:0]   ramRdata;

    // Address bits above the word index alias and are intentionally dropped.
    logic unusedAddr;
    assign unusedAddr = ^aluoutM[31:AW+2];

    assign wordIdx = aluoutM[AW+1:2];
    assign lane    = aluoutM[1:0];
    assign aligned = (lane == 2'b00);

    // Completion: zero-wait requests finish in IDLE, otherwise the last
    // BUSY cycle. Dropping memreqM while BUSY is an abort, never a
    // completion, so nothing is written and no data is returned.
    always_comb begin
        complete = 1'b0;
        if (memreqM) begin
            complete = (state == IDLE) ? ZERO_WAIT : (cnt == '0);
        end
    end

    assign stallM = memreqM & ~complete;

    assign isStore      = complete & memwriteM;
    // sb can hit any lane; sw needs a word-aligned address.
    assign storeOk      = isStore & (sbM | aligned);
    assign misalignedSw = isStore & ~sbM & ~aligned;

    // A store completing in the same cycle reset is asserted is discarded.
    always_comb begin
        byteEn = 4'b0000;
        if (storeOk && !reset) begin
            byteEn = sbM ? laneMask(lane) : 4'b1111;
        end
    end

    // Byte stores replicate the byte to every lane; byteEn picks the one.
    assign wrData = sbM ? {4{writedataM[7:0]}} : writedataM;

    // Loads never set errM: the datapath issues lb as a word load with the
    // byte offset still in the address, so misaligned loads are legitimate.
    assign readdataM = (complete && !memwriteM) ? ramRdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            errM  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memreqM && !ZERO_WAIT) begin
                        state <= BUSY;
                        cnt   <= WAIT_LAST;
                    end
                end
                BUSY: begin
                    if (!memreqM || cnt == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
            if (misalignedSw) begin
                errM <= 1'b1;
            end
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) uRam (
        .clk   (clk),
        .byteEn(byteEn),
        .waddr (wordIdx),
        .wdata (wrData),
        .raddr (wordIdx),
        .rdata (ramRdata)
    );

endmodule
